// File: rtl/count_sequencer.sv
// rtl/count_sequencer.sv - debounced run/pause/clear sequencer driving a prescaled BCD digit
// Define COUNT_SEQ_HEX_EN to count the digit 0..15 instead of 0..9.
module count_sequencer #(
    parameter logic [23:0] MAX_COUNT       = 24'd10_000_000,
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        btn_run,
    input  logic        btn_clear,
    input  logic [7:0]  compare_sel,
    output logic [3:0]  digit,
    output logic        tick,
    output logic        wrap,
    output logic [1:0]  state,
    output logic [23:0] prescale
);

`ifdef COUNT_SEQ_HEX_EN
    localparam logic [3:0] LAST_DIGIT = 4'd15;
`else
    localparam logic [3:0] LAST_DIGIT = 4'd9;
`endif

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_RUN   = 2'b01,
        S_PAUSE = 2'b10
    } state_t;

    // Bit 0 is the run button path, bit 1 the clear button path.
    logic [1:0]       sync1_q, sync1_d;
    logic [1:0]       sync2_q, sync2_d;
    logic [1:0]       db_q, db_d;
    logic [1:0]       db_prev_q, db_prev_d;
    logic [1:0][15:0] cnt_q, cnt_d;

    state_t      state_q, state_d;
    logic [23:0] prescale_q, prescale_d;
    logic [3:0]  digit_q, digit_d;
    logic        tick_q, tick_d;
    logic        wrap_q, wrap_d;

    logic        run_press;
    logic        clear_press;
    logic [23:0] compare;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            db_q       <= '0;
            db_prev_q  <= '0;
            cnt_q      <= '0;
            state_q    <= S_IDLE;
            prescale_q <= '0;
            digit_q    <= '0;
            tick_q     <= 1'b0;
            wrap_q     <= 1'b0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            db_q       <= db_d;
            db_prev_q  <= db_prev_d;
            cnt_q      <= cnt_d;
            state_q    <= state_d;
            prescale_q <= prescale_d;
            digit_q    <= digit_d;
            tick_q     <= tick_d;
            wrap_q     <= wrap_d;
        end
    end

    always_comb begin
        sync1_d   = {btn_clear, btn_run};
        sync2_d   = sync1_q;
        db_d      = db_q;
        db_prev_d = db_q;
        cnt_d     = cnt_q;
        for (int i = 0; i < 2; i++) begin
            if (sync2_q[i] == db_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == DEBOUNCE_CYCLES - 16'd1) begin
                db_d[i]  = sync2_q[i];
                cnt_d[i] = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + 16'd1;
            end
        end
    end

    // Press events fire on the debounced rising edge only; releases are silent.
    assign run_press   = db_q[0] & ~db_prev_q[0];
    assign clear_press = db_q[1] & ~db_prev_q[1];

    assign compare = (compare_sel == 8'd0) ? MAX_COUNT : {6'b0, compare_sel, 10'b0};

    always_comb begin
        state_d    = state_q;
        prescale_d = prescale_q;
        digit_d    = digit_q;
        tick_d     = 1'b0;
        wrap_d     = 1'b0;
        case (state_q)
            S_IDLE: begin
                prescale_d = '0;
                if (run_press) state_d = S_RUN;
            end
            S_RUN: begin
                // >= rather than == so a lowered compare terminates at once.
                if (prescale_q >= compare) begin
                    prescale_d = '0;
                    tick_d     = 1'b1;
                    if (digit_q == LAST_DIGIT) begin
                        digit_d = '0;
                        wrap_d  = 1'b1;
                    end else begin
                        digit_d = digit_q + 4'd1;
                    end
                end else begin
                    prescale_d = prescale_q + 24'd1;
                end
                if (run_press) state_d = S_PAUSE;
            end
            S_PAUSE: begin
                if (run_press) state_d = S_RUN;
            end
            default: state_d = S_IDLE;
        endcase
        if (clear_press) begin
            state_d    = S_IDLE;
            prescale_d = '0;
            digit_d    = '0;
            tick_d     = 1'b0;
            wrap_d     = 1'b0;
        end
    end

    assign digit    = digit_q;
    assign tick     = tick_q;
    assign wrap     = wrap_q;
    assign state    = state_q;
    assign prescale = prescale_q;

endmodule

// File: tb/tb_count_sequencer.sv
// tb/tb_count_sequencer.sv - directed self-checking bench for count_sequencer
module tb_count_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        btn_run = 1'b0;
    logic        btn_clear = 1'b0;
    logic [7:0]  compare_sel = 8'd0;
    logic [3:0]  digit;
    logic        tick;
    logic        wrap;
    logic [1:0]  state;
    logic [23:0] prescale;

    int n_chk  = 0;
    int n_pass = 0;

    localparam logic [1:0] IDLE  = 2'b00;
    localparam logic [1:0] RUN   = 2'b01;
    localparam logic [1:0] PAUSE = 2'b10;

    count_sequencer #(
        .MAX_COUNT       (24'd9),
        .DEBOUNCE_CYCLES (16'd4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .btn_run     (btn_run),
        .btn_clear   (btn_clear),
        .compare_sel (compare_sel),
        .digit       (digit),
        .tick        (tick),
        .wrap        (wrap),
        .state       (state),
        .prescale    (prescale)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_digit"}, 32'(digit), 32'd0);
        check({tag, "_tick"}, 32'(tick), 32'd0);
        check({tag, "_wrap"}, 32'(wrap), 32'd0);
        check({tag, "_state"}, 32'(state), 32'(IDLE));
        check({tag, "_prescale"}, 32'(prescale), 32'd0);
    endtask

    initial begin
        // Reset state
        step(2);
        check_all_zero("reset");
        reset = 1'b0;
        step(2);
        check_all_zero("post_reset");

        // Start: RUN appears exactly at E2+4
        btn_run = 1'b1;
        step(6);
        check("start_before", 32'(state), 32'(IDLE));
        step(1);
        check("start_run", 32'(state), 32'(RUN));
        check("start_prescale", 32'(prescale), 32'd0);
        step(3);
        btn_run = 1'b0;
        check("count_p3", 32'(prescale), 32'd3);
        step(6);
        check("first_pre_tick", 32'(tick), 32'd0);
        check("first_pre_p9", 32'(prescale), 32'd9);
        step(1);
        check("first_tick", 32'(tick), 32'd1);
        check("first_digit", 32'(digit), 32'd1);
        check("first_wrap", 32'(wrap), 32'd0);
        check("first_p0", 32'(prescale), 32'd0);
        for (int k = 2; k <= 10; k++) begin
            step(9);
            check("period_gap", 32'(tick), 32'd0);
            step(1);
            check("period_tick", 32'(tick), 32'd1);
            check("period_digit", 32'(digit), 32'(k % 10));
            check("period_wrap", 32'(wrap), (k == 10) ? 32'd1 : 32'd0);
        end
        step(1);
        check("pulse_tick_low", 32'(tick), 32'd0);
        check("pulse_wrap_low", 32'(wrap), 32'd0);

        // Pause lands with prescale at 5 (press 7 edges earlier, crossing one tick)
        step(7);
        btn_run = 1'b1;
        step(6);
        check("pause_before", 32'(state), 32'(RUN));
        check("pause_before_p", 32'(prescale), 32'd4);
        step(1);
        check("pause_state", 32'(state), 32'(PAUSE));
        check("pause_p5", 32'(prescale), 32'd5);
        check("pause_digit", 32'(digit), 32'd1);
        btn_run = 1'b0;
        step(15);
        check("pause_hold_p", 32'(prescale), 32'd5);
        check("pause_hold_digit", 32'(digit), 32'd1);
        check("pause_hold_state", 32'(state), 32'(PAUSE));
        btn_run = 1'b1;
        step(7);
        check("resume_state", 32'(state), 32'(RUN));
        check("resume_p5", 32'(prescale), 32'd5);
        step(4);
        check("resume_pre_tick", 32'(tick), 32'd0);
        step(1);
        check("resume_tick", 32'(tick), 32'd1);
        check("resume_digit", 32'(digit), 32'd2);
        btn_run = 1'b0;
        step(10);

        // Glitch of 3 cycles is ignored; 6-cycle hold gives exactly one transition
        btn_run = 1'b1;
        step(3);
        btn_run = 1'b0;
        step(10);
        check("glitch_ignored", 32'(state), 32'(RUN));
        btn_run = 1'b1;
        step(6);
        btn_run = 1'b0;
        step(10);
        check("hold6_one_edge", 32'(state), 32'(PAUSE));

        // Clear and run together: clear wins
        btn_run = 1'b1;
        btn_clear = 1'b1;
        step(6);
        check("both_before", 32'(state), 32'(PAUSE));
        step(1);
        check("both_state", 32'(state), 32'(IDLE));
        check("both_digit", 32'(digit), 32'd0);
        check("both_prescale", 32'(prescale), 32'd0);
        btn_run = 1'b0;
        btn_clear = 1'b0;
        step(10);
        check("both_no_run", 32'(state), 32'(IDLE));

        // Lowering compare mid-count terminates on the next edge
        compare_sel = 8'h01;
        btn_run = 1'b1;
        step(7);
        btn_run = 1'b0;
        check("cmp_run", 32'(state), 32'(RUN));
        step(500);
        check("cmp_p500", 32'(prescale), 32'd500);
        check("cmp_digit0", 32'(digit), 32'd0);
        compare_sel = 8'h00;
        step(1);
        check("cmp_tick", 32'(tick), 32'd1);
        check("cmp_p0", 32'(prescale), 32'd0);
        check("cmp_digit1", 32'(digit), 32'd1);
        step(9);
        check("cmp_gap", 32'(tick), 32'd0);
        step(1);
        check("cmp_period", 32'(tick), 32'd1);
        check("cmp_digit2", 32'(digit), 32'd2);

        // Asynchronous reset mid-count at digit 7
        step(50);
        check("pre_reset_digit", 32'(digit), 32'd7);
        step(3);
        #2;
        reset = 1'b1;
        #1;
        check_all_zero("async_reset");
        btn_run = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        step(6);
        check("rel_no_event", 32'(state), 32'(IDLE));
        step(1);
        check("rel_run", 32'(state), 32'(RUN));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/count_sequencer.md
# count_sequencer

Run/pause/clear controller for the single-digit seconds counter and 7-segment path. It debounces two raw push-buttons and runs a three-state FSM (IDLE/RUN/PAUSE). It gates a 24-bit prescaler with a selectable compare value and advances the BCD digit that feeds `seg7`. It sits between the top-level `ui_in` inputs and the display decoder, replacing a free-running counter with a user-sequenced one.

## Interface
- `MAX_COUNT`, 24'd10_000_000, prescaler compare value used when `compare_sel == 0`.
- `DEBOUNCE_CYCLES`, 16'd50_000, consecutive stable cycles required before a button level is accepted (legal range 1..65535).
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `btn_run` in 1: raw start/stop button, asynchronous to `clk`, active high.
- `btn_clear` in 1: raw clear button, asynchronous to `clk`, active high.
- `compare_sel` in 8: 0 selects `MAX_COUNT`; otherwise compare = {6'b0, compare_sel, 10'b0}.
- `digit` out 4: current digit, drives `seg7.counter`.
- `tick` out 1: one-cycle pulse on each digit advance.
- `wrap` out 1: one-cycle pulse when the digit wraps to 0 (coincident with `tick`).
- `state` out 2: 2'b00 IDLE, 2'b01 RUN, 2'b10 PAUSE. 2'b11 is never driven.
- `prescale` out 24: current prescaler value, for debug and `uio_out`.

## Operation
- Reset values: `digit`=0, `tick`=0, `wrap`=0, `state`=IDLE, `prescale`=0, sync flops=0, debounced levels=0, debounce counters=0.
- Each button path: 2-flop synchronizer, then debouncer.
  - Debouncer counter clears whenever the synced level equals the debounced level.
  - Otherwise the counter increments. When it reaches `DEBOUNCE_CYCLES`, the debounced level takes the synced value and the counter clears.
  - Press event = debounced 0→1, a one-cycle internal pulse. Releases generate no event.
- FSM on `run_press`: IDLE→RUN, RUN→PAUSE, PAUSE→RUN.
- FSM on `clear_press`: from any state → IDLE, with `prescale`=0 and `digit`=0.
  - If `clear_press` and `run_press` occur in the same cycle, clear wins and `run_press` is dropped.
- Prescaler:
  - Increments only in RUN. Holds in PAUSE. Is forced to 0 in IDLE.
  - Terminal condition is `prescale >= compare` (unsigned 24-bit). Lowering `compare_sel` mid-count therefore terminates on the next cycle instead of wrapping through 2^24.
  - On terminal: `prescale` ← 0, `tick` ← 1, digit advances.
- Digit advance: 0..9 then 0. On the 9→0 advance `wrap` ← 1.
- RUN→PAUSE in the same cycle as terminal: the terminal action completes (tick, advance), then the FSM pauses.
- `compare` is sampled combinationally each cycle and is not latched.

## Timing
- Period in RUN: compare+1 cycles per tick (MAX_COUNT+1 with default select).
- `tick`, `wrap`, `digit`, and `prescale` all update on the same edge. `tick` and `wrap` are high for exactly one cycle.
- Button latency, with a raw level change held stable and edge E0 being the first edge that samples it into sync stage 1:
  - Synced level valid after E1.
  - Debounced level updates at E1+`DEBOUNCE_CYCLES`.
  - `state` changes at E2+`DEBOUNCE_CYCLES`.
- Glitches shorter than `DEBOUNCE_CYCLES` cycles produce no event.
- Asynchronous `reset` mid-count clears all registers immediately. No press event is produced on reset release, even if a button is held (debounced level starts at 0 and must see `DEBOUNCE_CYCLES` stable cycles).
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Configuration
- `COUNT_SEQ_HEX_EN` defined: the digit counts 0..15. `wrap` pulses on the 15→0 advance. `seg7` must decode A–F.
- Undefined (default): the digit counts 0..9, as described above. Values 10..15 are unreachable.

## Test plan
Bench parameters: `MAX_COUNT`=24'd9, `DEBOUNCE_CYCLES`=4.
- Reset, hold `btn_run` high for 10 cycles → `state`=RUN at E2+4. `tick` every 10 cycles. `digit` 0→1→…→9→0 with `wrap` on the 10th tick only.
- In RUN with `prescale`=5, press `btn_run` → `state`=PAUSE, `prescale` holds at 5 and `digit` holds. Press again → resumes, next `tick` after 4 more cycles.
- `btn_run` pulsed high for 3 cycles → no state change. Held for 6 cycles → exactly one transition.
- `btn_clear` and `btn_run` rise on the same edge, held → `state`=IDLE, `digit`=0, `prescale`=0. No RUN entry.
- `compare_sel`=8'h01 (compare=1024) with `prescale` at 500, then `compare_sel`←0 → `tick` on the next edge (500 >= 9), after which the period is 10 cycles.
- Assert `reset` asynchronously mid-count with `digit`=7 → all outputs 0 / IDLE before the next clock edge. Release `reset` with `btn_run` held → no event until 4 stable cycles after sync.
